fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch (F) stage of the P6 five-stage MIPS pipeline; sits directly upstream of the F/D pipeline register and feeds it IR, pc and pc8.
- Owns the program counter and drives a synchronous-read instruction memory with 1-cycle read latency.
- Absorbs downstream stalls with a one-entry skid buffer.
- Applies branch/jump redirects from D, keeping the MIPS delay-slot instruction and squashing the wrong-path fetch behind it.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first instruction fetched after reset.
- IM_AW, 10, instruction-memory word-address width (1024 words).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  1 = downstream F/D register holds this cycle; current output is not consumed.
- redirect  in  1  1 = branch/jump taken in D this cycle.
- redirect_pc  in  32  target PC; valid when redirect=1.
- im_req  out  1  memory read strobe this cycle.
- im_addr  out  IM_AW  word address = (fetch_pc - RESET_PC) >> 2, truncated to IM_AW bits.
- im_rdata  in  32  read data, valid in the cycle after the im_req cycle.
- IR  out  32  instruction presented to F/D; 32'h0 (nop) whenever valid=0.
- pc  out  32  address of the presented instruction; 0 when valid=0.
- pc8  out  32  pc + 8 (link address); 0 when valid=0.
- valid  out  1  1 = IR/pc/pc8 carry a real instruction.

Behaviour:
- State:
  - fetch_pc (32): next address to request.
  - resp_pend, resp_pc, resp_squash: the single outstanding read.
  - skid_valid, skid_ir, skid_pc: the skid buffer.
- Reset (async, reset=0):
  - fetch_pc=RESET_PC.
  - resp_pend=0, resp_squash=0, skid_valid=0.
  - Outputs IR=0, pc=0, pc8=0, valid=0, im_req=0.
  - Reset mid-operation discards every pending response.
- Issue: im_req = reset & ~stall. On an issue edge: resp_pend<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4. No issue while stalled, so at most one read is outstanding.
- First request is in the first cycle after reset release; RESET_PC's instruction is presented with valid=1 one cycle later.
- Output select:
  - If skid_valid: present skid_ir/skid_pc.
  - Else if resp_pend & ~resp_squash: present im_rdata/resp_pc.
  - Else: bubble (valid=0, all zero).
- pc8 = pc + 8, with 32-bit wrap.
- Stall with a live memory response presented: on the edge, skid_valid<=1, skid_ir<=im_rdata, skid_pc<=resp_pc, resp_pend<=0.
- Stall with skid already valid: hold everything. Outputs stay stable for any stall length.
- stall=0 with skid_valid: skid is consumed (skid_valid<=0) and the new issue proceeds in the same cycle.
- Redirect is sampled only when stall=0; the hazard unit never raises it under stall, and fetch ignores it if it does.
- Redirect edge:
  - fetch_pc<=redirect_pc.
  - The read issued in the redirect cycle (pc+8 of the branch) is marked resp_squash=1 and presented as a bubble next cycle.
  - The instruction presented during the redirect cycle (the delay slot) is accepted normally.
  - The target is presented 2 cycles after the redirect cycle.
- Back-to-back redirects: the later redirect wins. Each redirect squashes the read issued in its own cycle.
- Addresses below RESET_PC or beyond IM_AW words wrap modulo 2^IM_AW words; there is no fault.
- pc values are word-aligned. The low 2 bits of redirect_pc are ignored (forced 0).

Decomposition:
- Shared package cpu_defs: RESET_PC value, NOP encoding 32'h0, instruction and address width constants.
- One sub-module: fetch_skid (the 1-entry skid register with valid/ir/pc and its capture/consume logic).
- PC and next-PC logic stay in fetch_unit.

Test Plan:
- Reset release, IM[0..3]=I0..I3, stall=0 -> valid=0 in cycle 0; then pc=0x3000/IR=I0, 0x3004/I1, 0x3008/I2 on successive cycles; pc8=pc+8.
- Stall held 3 cycles while pc=0x3004/I1 is presented -> output stays 0x3004/I1 and im_req=0 throughout; after release, 0x3008/I2 follows next cycle with no loss or duplicate.
- Redirect to 0x3040 in the cycle that presents delay slot 0x3008 -> next cycle valid=0, IR=0; following cycle pc=0x3040, IR=IM[16], pc8=0x3048.
- Redirect on two consecutive cycles (0x3040 then 0x3080) -> two bubbles, then pc=0x3080; no 0x3040 instruction is presented.
- Async reset asserted mid-stall with skid full -> outputs go to 0 immediately without a clock edge; after release, fetch restarts at 0x3000.
- redirect=1 together with stall=1 -> ignored: fetch_pc and outputs unchanged, next fetch continues sequentially.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared constants for the P6 pipeline front end: reset vector, nop encoding
// and datapath widths.
package cpu_defs;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int IM_AW_DEFAULT = 10;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

    // Instruction addresses are word aligned; the byte-offset bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register: holds the instruction that was on the F/D
// boundary when a stall arrived, so the memory response is not lost.
module fetch_skid
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_capture,
    input  logic               i_consume,
    input  logic [INSTR_W-1:0] i_ir,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_ir,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_pc;

    // Consume has priority: a capture is only requested while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ir    <= NOP;
            r_pc    <= '0;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_ir    <= i_ir;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_ir    = r_ir;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous
// instruction memory, absorbs stalls via a skid entry and applies D redirects.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IM_AW    = IM_AW_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      IR,
    output logic [31:0]      pc,
    output logic [31:0]      pc8,
    output logic             valid
);

    // Handshake: valid=1 offers IR/pc/pc8 to F/D; the offer is taken on the
    // next posedge iff stall=0, otherwise it is held unchanged until taken.

    logic [31:0] r_fetch_pc;
    logic        r_resp_pend;
    logic [31:0] r_resp_pc;
    logic        r_resp_squash;

    logic        w_resp_live;
    logic        w_skid_capture;
    logic        w_skid_valid;
    logic [31:0] w_skid_ir;
    logic [31:0] w_skid_pc;

    assign w_resp_live    = r_resp_pend & ~r_resp_squash;
    assign w_skid_capture = stall & ~w_skid_valid & w_resp_live;

    assign im_req  = reset & ~stall;
    assign im_addr = IM_AW'((r_fetch_pc - RESET_PC) >> 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pend   <= 1'b0;
            r_resp_pc     <= '0;
            r_resp_squash <= 1'b0;
        end else if (!stall) begin
            // The read issued alongside a redirect is the wrong-path fetch.
            r_resp_pend   <= 1'b1;
            r_resp_pc     <= r_fetch_pc;
            r_resp_squash <= redirect;
            r_fetch_pc    <= redirect ? word_align(redirect_pc) : r_fetch_pc + 32'd4;
        end else if (!w_skid_valid) begin
            // A live response moves into the skid; a squashed one is dropped.
            r_resp_pend <= 1'b0;
        end
    end

    fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .i_capture (w_skid_capture),
        .i_consume (~stall),
        .i_ir      (im_rdata),
        .i_pc      (r_resp_pc),
        .o_valid   (w_skid_valid),
        .o_ir      (w_skid_ir),
        .o_pc      (w_skid_pc)
    );

    always_comb begin
        valid = 1'b0;
        IR    = NOP;
        pc    = '0;
        if (w_skid_valid) begin
            valid = 1'b1;
            IR    = w_skid_ir;
            pc    = w_skid_pc;
        end else if (w_resp_live) begin
            valid = 1'b1;
            IR    = im_rdata;
            pc    = r_resp_pc;
        end
    end

    assign pc8 = valid ? pc + 32'd8 : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall hold, redirects,
// async reset with a full skid, and redirect ignored under stall.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic [31:0] IR;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;

    logic [31:0] mem [0:1023];
    logic [95:0] exp_q [$];
    logic [95:0] mon_e;
    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .IM_AW    (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .IR          (IR),
        .pc          (pc),
        .pc8         (pc8),
        .valid       (valid)
    );

    // Clock and instruction memory: IM[i] = 0xA000_0000 + i.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        im_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (im_req) im_rdata <= mem[im_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic expect_xfer(input logic [31:0] p, input logic [31:0] p8, input logic [31:0] ir);
        exp_q.push_back({p, p8, ir});
    endtask

    task automatic check_bubble(input string name);
        check({name, "_valid"}, {31'd0, valid}, 32'd0);
        check({name, "_ir"}, IR, 32'd0);
        check({name, "_pc"}, pc, 32'd0);
        check({name, "_pc8"}, pc8, 32'd0);
    endtask

    // Monitor: every accepted instruction (valid & ~stall) must match the queue head.
    always @(negedge clk) begin
        if (reset && valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_xfer: got pc %h expected no transfer", pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_pc", pc, mon_e[95:64]);
                check("xfer_pc8", pc8, mon_e[63:32]);
                check("xfer_ir", IR, mon_e[31:0]);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_bubble("reset");
        check("reset_im_req", {31'd0, im_req}, 32'd0);

        // Cycle 0 after release: first request, nothing presented yet.
        reset = 1'b1;
        @(negedge clk);
        check("c0_valid", {31'd0, valid}, 32'd0);
        check("c0_im_req", {31'd0, im_req}, 32'd1);
        check("c0_im_addr", {22'd0, im_addr}, 32'd0);

        tick(); expect_xfer(32'h3000, 32'h3008, 32'hA000_0000);   // c1
        tick(); drive(1'b1, 1'b0, 32'h0);                         // c2: stall on 0x3004
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h3004);
            check("stall_ir", IR, 32'hA000_0001);
            check("stall_im_req", {31'd0, im_req}, 32'd0);
            if (k < 2) tick();
        end
        tick(); drive(1'b0, 1'b0, 32'h0);                         // c5
        expect_xfer(32'h3004, 32'h300C, 32'hA000_0001);
        tick(); drive(1'b0, 1'b1, 32'h3040);                      // c6: delay slot 0x3008
        expect_xfer(32'h3008, 32'h3010, 32'hA000_0002);
        tick(); drive(1'b0, 1'b0, 32'h0);                         // c7
        @(negedge clk); check_bubble("redir_bubble");
        tick(); expect_xfer(32'h3040, 32'h3048, 32'hA000_0010);   // c8
        tick(); drive(1'b0, 1'b1, 32'h3040);                      // c9
        expect_xfer(32'h3044, 32'h304C, 32'hA000_0011);
        tick(); drive(1'b0, 1'b1, 32'h3083);                      // c10: low bits ignored
        @(negedge clk); check_bubble("b2b_bubble1");
        tick(); drive(1'b0, 1'b0, 32'h0);                         // c11
        @(negedge clk); check_bubble("b2b_bubble2");
        tick(); drive(1'b1, 1'b1, 32'h3100);                      // c12: redirect under stall
        @(negedge clk);
        check("rs_pc", pc, 32'h3080);
        check("rs_ir", IR, 32'hA000_0020);
        check("rs_im_req", {31'd0, im_req}, 32'd0);
        tick(); drive(1'b0, 1'b0, 32'h0);                         // c13
        expect_xfer(32'h3080, 32'h3088, 32'hA000_0020);
        @(negedge clk); check("rs_im_addr", {22'd0, im_addr}, 32'h21);
        tick(); expect_xfer(32'h3084, 32'h308C, 32'hA000_0021);   // c14
        tick(); drive(1'b1, 1'b0, 32'h0);                         // c15: 0x3088 into skid
        tick();                                                   // c16: skid full
        check("skid_pc", pc, 32'h3088);
        check("skid_ir", IR, 32'hA000_0022);

        // Async reset mid-cycle, no clock edge in between.
        #1 reset = 1'b0;
        #1;
        check_bubble("async_rst");
        check("async_rst_im_req", {31'd0, im_req}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;                                          // c0'
        @(negedge clk);
        check("restart_valid", {31'd0, valid}, 32'd0);
        check("restart_im_addr", {22'd0, im_addr}, 32'd0);
        tick(); expect_xfer(32'h3000, 32'h3008, 32'hA000_0000);
        tick(); expect_xfer(32'h3004, 32'h300C, 32'hA000_0001);
        tick(); expect_xfer(32'h3008, 32'h3010, 32'hA000_0002);
        tick(); drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
